// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared constants for the pipeline hazard/forwarding controller.
// Holds the forwarding-select encodings, the controller state encodings and
// the interlock-only stall depths per producing stage.
package hazard_forward_ctrl_pkg;

    // fwd_sel encodings, one 2-bit field per EX operand
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // controller state encodings
    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    // stall depth when no forwarding paths exist, by producer stage
    localparam logic [1:0] DEPTH_EX  = 2'd3;
    localparam logic [1:0] DEPTH_MEM = 2'd2;
    localparam logic [1:0] DEPTH_WB  = 2'd1;

endpackage

// File: rtl/hazard_forward_ctrl_sat_counter.sv
// Saturating up-counter used for the debug statistics.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset (clears the count)
//   inc   - increment request for this cycle
//   count - current value; holds at all ones instead of wrapping
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline.
// Detects RAW / load-use hazards on the instruction in ID, stalls the front
// end, flushes on taken branches and selects EX operand forwarding paths.
// Ports:
//   clk, rst (async, active-low)
//   id_*            - source operands of the instruction in ID
//   ex_*/mem_*/wb_* - destination info of the instructions downstream
//   branch_taken    - branch resolved taken in stage BR_STAGE
//   pc_write_en, ifid_write_en, idex_bubble - stall controls
//   flush_vec       - bit k flushes the pipeline register after stage k
//   fwd_sel         - 2 bits per EX operand (RF / EX-MEM / MEM-WB)
//   stall_active, stall_cycles, flush_events - debug status/statistics
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned BR_STAGE = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_src_addr,
    input  logic [REG_AW-1:0]           ex_dst_addr,
    input  logic                        ex_reg_write,
    input  logic                        ex_mem_read,
    input  logic [REG_AW-1:0]           mem_dst_addr,
    input  logic                        mem_reg_write,
    input  logic [REG_AW-1:0]           wb_dst_addr,
    input  logic                        wb_reg_write,
    input  logic                        branch_taken,
    output logic                        pc_write_en,
    output logic                        ifid_write_en,
    output logic                        idex_bubble,
    output logic [BR_STAGE-1:0]         flush_vec,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        stall_active,
    output logic [CNT_W-1:0]            stall_cycles,
    output logic [CNT_W-1:0]            flush_events
);

    logic [1:0]        state_d, state_q;
    logic [1:0]        cnt_d, cnt_q;
    logic [1:0]        req;
    logic              any_ex, any_mem, any_wb;
    logic [REG_AW-1:0] src;
    logic [REG_AW-1:0] exs;
    logic              stall;
    logic              flush;

    // Stall requirement of the instruction in ID; $0 never matches.
    always_comb begin
        any_ex  = 1'b0;
        any_mem = 1'b0;
        any_wb  = 1'b0;
        src     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src = id_src_addr[i*REG_AW +: REG_AW];
            if (id_src_used[i] && (src != '0)) begin
                if (ex_reg_write  && (src == ex_dst_addr))  any_ex  = 1'b1;
                if (mem_reg_write && (src == mem_dst_addr)) any_mem = 1'b1;
                if (wb_reg_write  && (src == wb_dst_addr))  any_wb  = 1'b1;
            end
        end
        req = 2'd0;
        if (FWD_EN != 0) begin
            if (any_ex && ex_mem_read) req = 2'd1;
        end else if (any_ex) begin
            req = DEPTH_EX;
        end else if (any_mem) begin
            req = DEPTH_MEM;
        end else if (any_wb) begin
            req = DEPTH_WB;
        end
    end

    // cnt_q holds the stall cycles still owed after the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (req != 2'd0) begin
                    stall   = 1'b1;
                    cnt_d   = req - 2'd1;
                    state_d = (cnt_d != 2'd0) ? ST_STALL : ST_RUN;
                end
            end
            ST_STALL: begin
                stall = 1'b1;
                if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
                state_d = (cnt_q <= 2'd1) ? ST_RUN : ST_STALL;
            end
            ST_FLUSH: begin
                // ID holds a flushed bubble: no hazard evaluation
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        // A taken branch overrides any new or ongoing stall.
        if (branch_taken) begin
            stall   = 1'b0;
            flush   = 1'b1;
            cnt_d   = '0;
            state_d = ST_FLUSH;
        end
        // Outputs are forced to their idle values while reset is held.
        if (!rst) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // EX operand forwarding; MEM result is newer than WB so it wins.
    always_comb begin
        fwd_sel = '0;
        exs     = '0;
        if ((FWD_EN != 0) && rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                exs = ex_src_addr[i*REG_AW +: REG_AW];
                if (mem_reg_write && (exs != '0) && (exs == mem_dst_addr)) begin
                    fwd_sel[2*i +: 2] = FWD_EXMEM;
                end else if (wb_reg_write && (exs != '0) && (exs == wb_dst_addr)) begin
                    fwd_sel[2*i +: 2] = FWD_MEMWB;
                end else begin
                    fwd_sel[2*i +: 2] = FWD_RF;
                end
            end
        end
    end

    assign pc_write_en   = ~stall;
    assign ifid_write_en = ~stall;
    assign idex_bubble   = stall;
    assign stall_active  = stall;
    assign flush_vec     = flush ? '1 : '0;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_events)
    );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: one forwarding instance (BR_STAGE=3, 32-bit
// counters) and one interlock-only instance (BR_STAGE=2, 4-bit counters so
// saturation is reached), both driven by the same inputs.
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] id_src_addr = '0;
    logic [1:0] id_src_used = '0;
    logic [9:0] ex_src_addr = '0;
    logic [4:0] ex_dst_addr = '0;
    logic       ex_reg_write = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] mem_dst_addr = '0;
    logic       mem_reg_write = 1'b0;
    logic [4:0] wb_dst_addr = '0;
    logic       wb_reg_write = 1'b0;
    logic       branch_taken = 1'b0;

    logic        a_pc, a_ifid, a_bub, a_stall;
    logic [2:0]  a_flush;
    logic [3:0]  a_fwd;
    logic [31:0] a_sc, a_fe;
    logic        b_pc, b_ifid, b_bub, b_stall;
    logic [1:0]  b_flush;
    logic [3:0]  b_fwd;
    logic [3:0]  b_sc, b_fe;

    int n_checks = 0;
    int n_errors = 0;

    // reference state: owed stall cycles, "previous cycle was a branch", stats
    int     rem_a = 0, rem_b = 0;
    bit     fl_a = 0, fl_b = 0;
    longint sc_a = 0, fe_a = 0, sc_b = 0, fe_b = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_AW(5), .NUM_SRC(2), .FWD_EN(1), .BR_STAGE(3), .CNT_W(32)) u_fwd (
        .clk(clk), .rst(rst), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .ex_src_addr(ex_src_addr), .ex_dst_addr(ex_dst_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_dst_addr(mem_dst_addr), .mem_reg_write(mem_reg_write),
        .wb_dst_addr(wb_dst_addr), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken),
        .pc_write_en(a_pc), .ifid_write_en(a_ifid), .idex_bubble(a_bub), .flush_vec(a_flush),
        .fwd_sel(a_fwd), .stall_active(a_stall), .stall_cycles(a_sc), .flush_events(a_fe)
    );

    hazard_forward_ctrl #(.REG_AW(5), .NUM_SRC(2), .FWD_EN(0), .BR_STAGE(2), .CNT_W(4)) u_ilk (
        .clk(clk), .rst(rst), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .ex_src_addr(ex_src_addr), .ex_dst_addr(ex_dst_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_dst_addr(mem_dst_addr), .mem_reg_write(mem_reg_write),
        .wb_dst_addr(wb_dst_addr), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken),
        .pc_write_en(b_pc), .ifid_write_en(b_ifid), .idex_bubble(b_bub), .flush_vec(b_flush),
        .fwd_sel(b_fwd), .stall_active(b_stall), .stall_cycles(b_sc), .flush_events(b_fe)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int src_of(input logic [9:0] v, input int i);
        return int'(v[i*5 +: 5]);
    endfunction

    // Stall cycles the instruction in ID needs, straight from the hazard rules.
    function automatic int model_req(input bit fwd);
        int need = 0;
        for (int i = 0; i < 2; i++) begin
            int s = src_of(id_src_addr, i);
            if (id_src_used[i] && s != 0) begin
                if (fwd) begin
                    if (ex_reg_write && ex_mem_read && s == int'(ex_dst_addr)) need = 1;
                end else begin
                    if (ex_reg_write && s == int'(ex_dst_addr) && need < 3) need = 3;
                    if (mem_reg_write && s == int'(mem_dst_addr) && need < 2) need = 2;
                    if (wb_reg_write && s == int'(wb_dst_addr) && need < 1) need = 1;
                end
            end
        end
        return need;
    endfunction

    function automatic logic [3:0] model_fwd();
        logic [3:0] r = '0;
        for (int i = 0; i < 2; i++) begin
            int s = src_of(ex_src_addr, i);
            int code = 0;
            if (s != 0 && mem_reg_write && s == int'(mem_dst_addr)) code = 1;
            else if (s != 0 && wb_reg_write && s == int'(wb_dst_addr)) code = 2;
            r = r | (4'(code) << (2 * i));
        end
        return r;
    endfunction

    function automatic longint sat_inc(input longint v, input longint maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Check one cycle with the inputs currently driven, then advance the model
    // and the clock. Called #1 after a rising edge.
    task automatic step();
        int ra, rb;
        bit sa, sb;
        #3;
        ra = model_req(1'b1);
        rb = model_req(1'b0);
        sa = 0;
        sb = 0;
        if (!branch_taken) begin
            sa = (rem_a > 0) || (!fl_a && ra > 0);
            sb = (rem_b > 0) || (!fl_b && rb > 0);
        end
        check("a_pc_write_en", a_pc, !sa);
        check("a_ifid_write_en", a_ifid, !sa);
        check("a_idex_bubble", a_bub, sa);
        check("a_stall_active", a_stall, sa);
        check("a_flush_vec", a_flush, branch_taken ? 3'b111 : 3'b000);
        check("a_fwd_sel", a_fwd, model_fwd());
        check("a_stall_cycles", a_sc, sc_a);
        check("a_flush_events", a_fe, fe_a);
        check("b_pc_write_en", b_pc, !sb);
        check("b_idex_bubble", b_bub, sb);
        check("b_stall_active", b_stall, sb);
        check("b_flush_vec", b_flush, branch_taken ? 2'b11 : 2'b00);
        check("b_fwd_sel", b_fwd, 4'b0000);
        check("b_stall_cycles", b_sc, sc_b);
        check("b_flush_events", b_fe, fe_b);
        if (branch_taken) begin
            rem_a = 0; rem_b = 0; fl_a = 1; fl_b = 1;
            fe_a = sat_inc(fe_a, 64'hFFFF_FFFF);
            fe_b = sat_inc(fe_b, 15);
        end else begin
            if (rem_a > 0) rem_a--; else if (!fl_a && ra > 0) rem_a = ra - 1;
            if (rem_b > 0) rem_b--; else if (!fl_b && rb > 0) rem_b = rb - 1;
            fl_a = 0; fl_b = 0;
        end
        if (sa) sc_a = sat_inc(sc_a, 64'hFFFF_FFFF);
        if (sb) sc_b = sat_inc(sc_b, 15);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_src_addr = '0; id_src_used = '0; ex_src_addr = '0;
        ex_dst_addr = '0; ex_reg_write = 0; ex_mem_read = 0;
        mem_dst_addr = '0; mem_reg_write = 0;
        wb_dst_addr = '0; wb_reg_write = 0; branch_taken = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_pc"}, a_pc, 1'b1);
        check({tag, "_a_ifid"}, a_ifid, 1'b1);
        check({tag, "_a_bubble"}, a_bub, 1'b0);
        check({tag, "_a_flush"}, a_flush, 3'b000);
        check({tag, "_a_fwd"}, a_fwd, 4'b0000);
        check({tag, "_a_stall"}, a_stall, 1'b0);
        check({tag, "_a_sc"}, a_sc, 32'd0);
        check({tag, "_a_fe"}, a_fe, 32'd0);
        check({tag, "_b_pc"}, b_pc, 1'b1);
        check({tag, "_b_bubble"}, b_bub, 1'b0);
        check({tag, "_b_flush"}, b_flush, 2'b00);
        check({tag, "_b_sc"}, b_sc, 4'd0);
    endtask

    // Hazard-provoking inputs: EX load writing $5 read by ID src0, forwardable
    // EX operand, and a branch -- all of which reset must mask.
    task automatic drive_hazard_and_branch();
        id_src_addr = {5'd0, 5'd5}; id_src_used = 2'b01;
        ex_dst_addr = 5'd5; ex_reg_write = 1; ex_mem_read = 1;
        ex_src_addr = {5'd0, 5'd7}; mem_dst_addr = 5'd7; mem_reg_write = 1;
        branch_taken = 1;
    endtask

    initial begin
        clear_inputs();
        drive_hazard_and_branch();
        #12;
        check_reset_outputs("rst_init");
        #1 rst = 1'b1;               // released between edges
        clear_inputs();
        @(posedge clk); #1;

        // lw $2 in EX, ID reads $2
        ex_mem_read = 1; ex_reg_write = 1; ex_dst_addr = 5'd2;
        id_src_addr = {5'd0, 5'd2}; id_src_used = 2'b01;
        step();
        clear_inputs();
        step(); step(); step();
        check("lw_stall_cycles", a_sc, 32'd1);

        // forwarding priority and $0
        ex_src_addr = {5'd3, 5'd0};
        mem_reg_write = 1; mem_dst_addr = 5'd3; wb_reg_write = 1; wb_dst_addr = 5'd3;
        step();
        check("fwd_mem_prio", a_fwd[3:2], 2'b01);
        mem_reg_write = 0;
        step();
        mem_dst_addr = 5'd0; wb_dst_addr = 5'd0; mem_reg_write = 1;
        ex_src_addr = {5'd0, 5'd0};
        step();
        clear_inputs();

        // interlock depths: EX, MEM, WB match on $5 (fresh counters first)
        rst = 0; #1 rst = 1;
        rem_a = 0; rem_b = 0; fl_a = 0; fl_b = 0; sc_a = 0; fe_a = 0; sc_b = 0; fe_b = 0;
        id_src_addr = {5'd0, 5'd5}; id_src_used = 2'b01;
        ex_reg_write = 1; ex_dst_addr = 5'd5;
        step(); ex_reg_write = 0; step(); step();
        mem_reg_write = 1; mem_dst_addr = 5'd5;
        step(); mem_reg_write = 0; step();
        wb_reg_write = 1; wb_dst_addr = 5'd5;
        step(); wb_reg_write = 0;
        step();
        check("ilk_stall_total", b_sc, 4'd6);

        // branch pulse, then matching ID in the flush cycle
        branch_taken = 1; step();
        branch_taken = 0; ex_reg_write = 1; ex_dst_addr = 5'd5; ex_mem_read = 1;
        step();
        clear_inputs(); step(); step(); step();

        // branch in 2nd cycle of a 3-cycle stall, hazard still present
        id_src_addr = {5'd0, 5'd5}; id_src_used = 2'b01;
        ex_reg_write = 1; ex_dst_addr = 5'd5;
        step();
        branch_taken = 1; step();
        branch_taken = 0; step(); step();
        clear_inputs(); step(); step(); step();

        // asynchronous reset in the middle of a stall
        id_src_addr = {5'd0, 5'd5}; id_src_used = 2'b01;
        ex_reg_write = 1; ex_dst_addr = 5'd5;
        step(); step();
        drive_hazard_and_branch();
        #2 rst = 0;
        #1 check_reset_outputs("rst_async");
        clear_inputs();
        rem_a = 0; rem_b = 0; fl_a = 0; fl_b = 0; sc_a = 0; fe_a = 0; sc_b = 0; fe_b = 0;
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        step(); step();

        // randomized traffic, small register range to provoke matches
        for (int n = 0; n < 3000; n++) begin
            id_src_addr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_src_used   = 2'($urandom);
            ex_src_addr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            ex_dst_addr   = 5'($urandom_range(0, 3));
            ex_reg_write  = 1'($urandom);
            ex_mem_read   = 1'($urandom);
            mem_dst_addr  = 5'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom);
            wb_dst_addr   = 5'($urandom_range(0, 3));
            wb_reg_write  = 1'($urandom);
            branch_taken  = ($urandom_range(0, 7) == 0);
            step();
        end
        check("b_counters_saturated", b_sc, 4'hF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
